// File: rtl/lifo_arbiter_if.sv
// Requester and stack-side signal bundle for lifo_arbiter.
// slave = the arbiter; master = requesters plus the stack model that feeds dataOut/flags.
interface lifo_arbiter_if #(parameter int DW = 4);
    logic          req0, req1;
    logic          rw0, rw1;
    logic [DW-1:0] din0, din1;
    logic          gnt0, gnt1;
    logic          done0, done1;
    logic          err0, err1;
    logic [DW-1:0] dout0, dout1;
    logic          busy;
    logic [DW-1:0] lifo_dataIn;
    logic          lifo_RW;
    logic          lifo_EN;
    logic [DW-1:0] lifo_dataOut;
    logic          lifo_EMPTY;
    logic          lifo_FULL;

    modport slave (
        input  req0, req1, rw0, rw1, din0, din1,
        input  lifo_dataOut, lifo_EMPTY, lifo_FULL,
        output gnt0, gnt1, done0, done1, err0, err1, dout0, dout1, busy,
        output lifo_dataIn, lifo_RW, lifo_EN
    );

    modport master (
        output req0, req1, rw0, rw1, din0, din1,
        output lifo_dataOut, lifo_EMPTY, lifo_FULL,
        input  gnt0, gnt1, done0, done1, err0, err1, dout0, dout1, busy,
        input  lifo_dataIn, lifo_RW, lifo_EN
    );
endinterface

// File: rtl/lifo_arbiter.sv
// Two-requester arbiter/sequencer in front of the shared LIFO stack.
// Define LIFO_ARB_RR_EN for round-robin arbitration; default is fixed priority (req0 first).
module lifo_arbiter #(
    parameter int DW = 4
) (
    input  logic          clk,
    input  logic          rst_n,
    lifo_arbiter_if.slave bus
);

    typedef enum logic [1:0] {IDLE, ISSUE, CAPT, RESP} state_t;

    state_t state;
    logic   win;
    logic   op_rw;
    logic   pick;
    logic   pick_rw;
    logic [DW-1:0] pick_din;
    logic   reject;

`ifdef LIFO_ARB_RR_EN
    logic ptr;

    always_comb pick = (bus.req0 && bus.req1) ? ptr : bus.req1;
`else
    always_comb pick = bus.req0 ? 1'b0 : 1'b1;
`endif

    // Flags are only trusted in IDLE; nothing else moves the stack.
    always_comb begin
        pick_rw  = pick ? bus.rw1  : bus.rw0;
        pick_din = pick ? bus.din1 : bus.din0;
        reject   = pick_rw ? bus.lifo_EMPTY : bus.lifo_FULL;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state           <= IDLE;
            win             <= 1'b0;
            op_rw           <= 1'b1;
            bus.gnt0        <= 1'b0;
            bus.gnt1        <= 1'b0;
            bus.done0       <= 1'b0;
            bus.done1       <= 1'b0;
            bus.err0        <= 1'b0;
            bus.err1        <= 1'b0;
            bus.dout0       <= '0;
            bus.dout1       <= '0;
            bus.busy        <= 1'b0;
            bus.lifo_dataIn <= '0;
            bus.lifo_RW     <= 1'b1;
            bus.lifo_EN     <= 1'b0;
`ifdef LIFO_ARB_RR_EN
            ptr             <= 1'b0;
`endif
        end else begin
            case (state)
                IDLE: begin
                    if (bus.req0 || bus.req1) begin
                        win      <= pick;
                        op_rw    <= pick_rw;
                        bus.gnt0 <= ~pick;
                        bus.gnt1 <= pick;
                        bus.busy <= 1'b1;
`ifdef LIFO_ARB_RR_EN
                        ptr      <= ~ptr;
`endif
                        if (reject) begin
                            state     <= RESP;
                            bus.done0 <= ~pick;
                            bus.done1 <= pick;
                            bus.err0  <= ~pick;
                            bus.err1  <= pick;
                        end else begin
                            state           <= ISSUE;
                            bus.lifo_EN     <= 1'b1;
                            bus.lifo_RW     <= pick_rw;
                            bus.lifo_dataIn <= pick_din;
                        end
                    end
                end
                ISSUE: begin
                    bus.lifo_EN <= 1'b0;
                    if (op_rw) begin
                        state <= CAPT;
                    end else begin
                        state     <= RESP;
                        bus.done0 <= ~win;
                        bus.done1 <= win;
                    end
                end
                CAPT: begin
                    if (win) bus.dout1 <= bus.lifo_dataOut;
                    else     bus.dout0 <= bus.lifo_dataOut;
                    bus.done0 <= ~win;
                    bus.done1 <= win;
                    state     <= RESP;
                end
                RESP: begin
                    bus.done0 <= 1'b0;
                    bus.done1 <= 1'b0;
                    bus.err0  <= 1'b0;
                    bus.err1  <= 1'b0;
                    bus.gnt0  <= 1'b0;
                    bus.gnt1  <= 1'b0;
                    bus.busy  <= 1'b0;
                    state     <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule
